branch_cmp_arbiter: RTL and testbench

- Shares one 32-bit branch `comparator` instance between NUM_REQ requesters, e.g. the branch unit and the SLT/SLTU path.
- Round-robin arbitration, one transaction in flight.
- Decodes the RISC-V branch funct3 into the comparator's unsigned control and a taken/not-taken result.
- Returns less/equal/taken to the winning requester over a valid/ready response handshake.

---
 rtl/branch_cmp_arbiter_if.sv | 52 +++++
 rtl/branch_cmp_arbiter.sv | 152 +++++++++++++++
 tb/tb_branch_cmp_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_cmp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp_arbiter_if
//  Description : Bundle of request / response / comparator signals shared
//                between branch_cmp_arbiter and its requesters.
//                slave  : arbiter side (drives grants, responses, comparator
//                         operands).
//                master : requester / environment side.
//  Ports       : i_req_valid/o_req_ready      per-requester request handshake
//                i_req_rs1/rs2_data, funct3    packed per-requester payload
//                o_rsp_valid/i_rsp_ready      per-requester response handshake
//                o_rsp_less/equal/taken/illegal shared response result
//                o_cmp_* / i_cmp_*             link to the shared comparator
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_cmp_arbiter_if #(
   parameter int NUM_REQ = 2
) ();
   logic [NUM_REQ-1:0]    i_req_valid;
   logic [NUM_REQ-1:0]    o_req_ready;
   logic [NUM_REQ*32-1:0] i_req_rs1_data;
   logic [NUM_REQ*32-1:0] i_req_rs2_data;
   logic [NUM_REQ*3-1:0]  i_req_funct3;
   logic [NUM_REQ-1:0]    o_rsp_valid;
   logic [NUM_REQ-1:0]    i_rsp_ready;
   logic                  o_rsp_less;
   logic                  o_rsp_equal;
   logic                  o_rsp_taken;
   logic                  o_rsp_illegal;
   logic [31:0]           o_cmp_rs1_data;
   logic [31:0]           o_cmp_rs2_data;
   logic                  o_cmp_br_un;
   logic                  i_cmp_br_less;
   logic                  i_cmp_br_equal;

   modport slave (
      input  i_req_valid, i_req_rs1_data, i_req_rs2_data, i_req_funct3,
      input  i_rsp_ready, i_cmp_br_less, i_cmp_br_equal,
      output o_req_ready, o_rsp_valid, o_rsp_less, o_rsp_equal,
      output o_rsp_taken, o_rsp_illegal,
      output o_cmp_rs1_data, o_cmp_rs2_data, o_cmp_br_un
   );

   modport master (
      output i_req_valid, i_req_rs1_data, i_req_rs2_data, i_req_funct3,
      output i_rsp_ready, i_cmp_br_less, i_cmp_br_equal,
      input  o_req_ready, o_rsp_valid, o_rsp_less, o_rsp_equal,
      input  o_rsp_taken, o_rsp_illegal,
      input  o_cmp_rs1_data, o_cmp_rs2_data, o_cmp_br_un
   );
endinterface
`default_nettype wire

// File: rtl/branch_cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp_arbiter
//  Description : Round-robin arbiter sharing one external 32-bit branch
//                comparator among NUM_REQ requesters. One transaction is in
//                flight at a time (IDLE -> CMP -> RESP). RISC-V branch funct3
//                is decoded into the comparator signedness control and a
//                taken / illegal result returned to the winning requester.
//  Ports       : i_clk   - clock
//                i_reset - synchronous active-high reset
//                bus     - branch_cmp_arbiter_if.slave (request, response and
//                          comparator signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   branch_cmp_arbiter_if.slave   bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMP  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]      r_state;
   logic [ID_W-1:0] r_rr_ptr;
   logic [ID_W-1:0] r_id;
   logic [31:0]     r_rs1;
   logic [31:0]     r_rs2;
   logic [2:0]      r_funct3;
   logic            r_less;
   logic            r_equal;
   logic            r_taken;
   logic            r_illegal;

   logic [NUM_REQ-1:0][31:0] w_rs1_arr;
   logic [NUM_REQ-1:0][31:0] w_rs2_arr;
   logic [NUM_REQ-1:0][2:0]  w_f3_arr;

   logic [ID_W-1:0] w_winner;
   logic [ID_W-1:0] w_idx;
   logic [ID_W:0]   w_sum;
   logic            w_found;
   logic            w_accept;
   logic            w_rsp_done;
   logic            w_taken;
   logic            w_illegal;

   // Unpack the flat per-requester buses and build the one-hot outputs.
   generate
      for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
         assign w_rs1_arr[k] = bus.i_req_rs1_data[32*k +: 32];
         assign w_rs2_arr[k] = bus.i_req_rs2_data[32*k +: 32];
         assign w_f3_arr[k]  = bus.i_req_funct3[3*k +: 3];
         assign bus.o_req_ready[k] = w_accept && (w_winner == ID_W'(k));
         assign bus.o_rsp_valid[k] = (r_state == ST_RESP) && (r_id == ID_W'(k));
      end
   endgenerate

   // Round-robin search starting just after the last served requester.
   // The running index is kept one bit wider so the wrap is a single
   // conditional subtract instead of a modulo.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         end
         w_idx = w_sum[ID_W-1:0];
         if (!w_found && bus.i_req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Reset blocks acceptance in the same cycle it is asserted.
   assign w_accept   = (r_state == ST_IDLE) && !i_reset && w_found;
   assign w_rsp_done = (r_state == ST_RESP) && bus.i_rsp_ready[r_id];

   // funct3 decode; 010/011 are flagged illegal but still compared.
   always_comb begin
      w_taken   = 1'b0;
      w_illegal = 1'b0;
      case (r_funct3)
         3'b000:         w_taken   = bus.i_cmp_br_equal;
         3'b001:         w_taken   = !bus.i_cmp_br_equal;
         3'b100, 3'b110: w_taken   = bus.i_cmp_br_less;
         3'b101, 3'b111: w_taken   = !bus.i_cmp_br_less;
         default:        w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_rr_ptr  <= ID_W'(NUM_REQ - 1);
         r_id      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_funct3  <= '0;
         r_less    <= 1'b0;
         r_equal   <= 1'b0;
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_rs1    <= w_rs1_arr[w_winner];
                  r_rs2    <= w_rs2_arr[w_winner];
                  r_funct3 <= w_f3_arr[w_winner];
                  r_id     <= w_winner;
                  r_state  <= ST_CMP;
               end
            end
            ST_CMP: begin
               r_less    <= bus.i_cmp_br_less;
               r_equal   <= bus.i_cmp_br_equal;
               r_taken   <= w_taken;
               r_illegal <= w_illegal;
               r_state   <= ST_RESP;
            end
            ST_RESP: begin
               if (w_rsp_done) begin
                  r_rr_ptr <= r_id;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_cmp_rs1_data = r_rs1;
   assign bus.o_cmp_rs2_data = r_rs2;
   assign bus.o_cmp_br_un    = r_funct3[1];
   assign bus.o_rsp_less     = r_less;
   assign bus.o_rsp_equal    = r_equal;
   assign bus.o_rsp_taken    = r_taken;
   assign bus.o_rsp_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_branch_cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_cmp_arbiter
//  Description : Directed self-checking bench for branch_cmp_arbiter with a
//                behavioural stand-in for the shared 32-bit comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_cmp_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   branch_cmp_arbiter_if #(.NUM_REQ(2)) bus ();

   branch_cmp_arbiter #(.NUM_REQ(2)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // External comparator: equality plus signed/unsigned less-than.
   assign bus.i_cmp_br_equal = (bus.o_cmp_rs1_data == bus.o_cmp_rs2_data);
   assign bus.i_cmp_br_less  = bus.o_cmp_br_un ?
                               (bus.o_cmp_rs1_data < bus.o_cmp_rs2_data) :
                               ($signed(bus.o_cmp_rs1_data) < $signed(bus.o_cmp_rs2_data));

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [2:0]  f3;
      logic        less;
      logic        eq;
      logic        taken;
      logic        ill;
      logic        brun;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst = 1'b1;
      bus.i_req_valid = 2'b00;
      bus.i_rsp_ready = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_req_valid = 2'b11;
      @(negedge clk);
      n_checks++; if (bus.o_req_ready !== 2'b00) begin n_errors++; $display("FAIL rst_ready_gated: got %b expected 00", bus.o_req_ready); end
      n_checks++; if (bus.o_rsp_valid !== 2'b00) begin n_errors++; $display("FAIL rst_rsp_valid: got %b expected 00", bus.o_rsp_valid); end
      rst = 1'b0;
      bus.i_req_valid = 2'b00;
      #1;
      n_checks++; if ({bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal} !== 4'b0000) begin
         n_errors++; $display("FAIL rst_results: got %b expected 0000", {bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal}); end
      n_checks++; if ({bus.o_cmp_rs1_data, bus.o_cmp_rs2_data, bus.o_cmp_br_un} !== 65'd0) begin
         n_errors++; $display("FAIL rst_cmp_out: got %h expected 0", {bus.o_cmp_rs1_data, bus.o_cmp_rs2_data, bus.o_cmp_br_un}); end
      bus.i_req_valid = 2'b11;
      #1;
      n_checks++; if (bus.o_req_ready !== 2'b01) begin n_errors++; $display("FAIL rst_first_winner: got %b expected 01", bus.o_req_ready); end
      bus.i_req_valid = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      vec_t v[7];
      int   waited;
      v[0] = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      v[1] = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      v[2] = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      v[3] = '{32'h12345678, 32'h12345678, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      v[4] = '{32'h12345678, 32'h12345678, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      v[5] = '{32'h12345678, 32'h12345678, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      v[6] = '{32'h00000001, 32'hFFFFFFFF, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         bus.i_req_rs1_data[31:0] = v[i].rs1;
         bus.i_req_rs2_data[31:0] = v[i].rs2;
         bus.i_req_funct3[2:0]    = v[i].f3;
         bus.i_rsp_ready          = 2'b11;
         bus.i_req_valid          = 2'b01;
         #1;
         waited = 0;
         while (bus.o_req_ready == 2'b00 && waited < 10) begin @(negedge clk); #1; waited++; end
         n_checks++; if (bus.o_req_ready !== 2'b01) begin n_errors++; $display("FAIL dec%0d_grant: got %b expected 01", i, bus.o_req_ready); end
         @(posedge clk); #1;
         bus.i_req_valid = 2'b00;
         @(negedge clk);
         n_checks++; if (bus.o_rsp_valid !== 2'b00) begin n_errors++; $display("FAIL dec%0d_early_valid: got %b expected 00", i, bus.o_rsp_valid); end
         n_checks++; if (bus.o_cmp_br_un !== v[i].brun) begin n_errors++; $display("FAIL dec%0d_br_un: got %b expected %b", i, bus.o_cmp_br_un, v[i].brun); end
         n_checks++; if (bus.o_cmp_rs1_data !== v[i].rs1 || bus.o_cmp_rs2_data !== v[i].rs2) begin
            n_errors++; $display("FAIL dec%0d_operands: got %h/%h expected %h/%h", i, bus.o_cmp_rs1_data, bus.o_cmp_rs2_data, v[i].rs1, v[i].rs2); end
         @(negedge clk);
         n_checks++; if (bus.o_rsp_valid !== 2'b01) begin n_errors++; $display("FAIL dec%0d_rsp_valid: got %b expected 01", i, bus.o_rsp_valid); end
         n_checks++; if ({bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal} !== {v[i].less, v[i].eq, v[i].taken, v[i].ill}) begin
            n_errors++; $display("FAIL dec%0d_result(less,eq,taken,ill): got %b expected %b", i,
               {bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal}, {v[i].less, v[i].eq, v[i].taken, v[i].ill}); end
         @(negedge clk);
         n_checks++; if (bus.o_rsp_valid !== 2'b00) begin n_errors++; $display("FAIL dec%0d_rsp_drop: got %b expected 00", i, bus.o_rsp_valid); end
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] grants[$];
      int         times[$];
      logic [1:0] exp_g[4];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      apply_reset();
      bus.i_req_rs1_data = {32'd3, 32'd4};
      bus.i_req_rs2_data = {32'd4, 32'd3};
      bus.i_req_funct3   = {3'b100, 3'b100};
      bus.i_rsp_ready    = 2'b11;
      bus.i_req_valid    = 2'b11;
      for (int c = 0; c < 30 && grants.size() < 4; c++) begin
         @(negedge clk);
         if (bus.o_req_ready != 2'b00) begin grants.push_back(bus.o_req_ready); times.push_back(c); end
      end
      n_checks++; if (grants.size() != 4) begin n_errors++; $display("FAIL rr_grant_count: got %0d expected 4", grants.size()); end
      for (int i = 0; i < grants.size(); i++) begin
         n_checks++; if (grants[i] !== exp_g[i]) begin n_errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, grants[i], exp_g[i]); end
      end
      for (int i = 1; i < times.size(); i++) begin
         n_checks++; if (times[i] - times[i-1] != 3) begin n_errors++; $display("FAIL rr_spacing%0d: got %0d expected 3", i, times[i] - times[i-1]); end
      end
      @(posedge clk); #1;
      bus.i_req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int waited;
      apply_reset();
      bus.i_req_rs1_data = {32'd7, 32'd5};
      bus.i_req_rs2_data = {32'd7, 32'd9};
      bus.i_req_funct3   = {3'b000, 3'b100};
      bus.i_rsp_ready    = 2'b10;
      bus.i_req_valid    = 2'b01;
      #1;
      waited = 0;
      while (bus.o_req_ready == 2'b00 && waited < 10) begin @(negedge clk); #1; waited++; end
      n_checks++; if (bus.o_req_ready !== 2'b01) begin n_errors++; $display("FAIL bp_grant0: got %b expected 01", bus.o_req_ready); end
      @(posedge clk); #1;
      bus.i_req_valid = 2'b10;
      @(negedge clk);
      n_checks++; if (bus.o_req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_ready_in_cmp: got %b expected 00", bus.o_req_ready); end
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         n_checks++; if (bus.o_rsp_valid !== 2'b01) begin n_errors++; $display("FAIL bp_hold_valid c%0d: got %b expected 01", c, bus.o_rsp_valid); end
         n_checks++; if ({bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal} !== 4'b1010) begin
            n_errors++; $display("FAIL bp_hold_result c%0d: got %b expected 1010", c, {bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal}); end
         n_checks++; if (bus.o_cmp_rs1_data !== 32'd5 || bus.o_cmp_rs2_data !== 32'd9 || bus.o_cmp_br_un !== 1'b0) begin
            n_errors++; $display("FAIL bp_hold_cmp c%0d: got %h/%h/%b expected 5/9/0", c, bus.o_cmp_rs1_data, bus.o_cmp_rs2_data, bus.o_cmp_br_un); end
         n_checks++; if (bus.o_req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_ready_blocked c%0d: got %b expected 00", c, bus.o_req_ready); end
         @(negedge clk);
      end
      bus.i_rsp_ready = 2'b01;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.o_req_ready !== 2'b10) begin n_errors++; $display("FAIL bp_grant1_after_release: got %b expected 10", bus.o_req_ready); end
      n_checks++; if (bus.o_rsp_valid !== 2'b00) begin n_errors++; $display("FAIL bp_rsp_released: got %b expected 00", bus.o_rsp_valid); end
      @(posedge clk); #1;
      bus.i_req_valid = 2'b00;
      bus.i_rsp_ready = 2'b10;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (bus.o_rsp_valid !== 2'b10) begin n_errors++; $display("FAIL bp_rsp1_valid: got %b expected 10", bus.o_rsp_valid); end
      n_checks++; if ({bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal} !== 4'b0110) begin
         n_errors++; $display("FAIL bp_rsp1_result: got %b expected 0110", {bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_taken, bus.o_rsp_illegal}); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_cmp();
      int   waited;
      logic seen0;
      logic seen1;
      apply_reset();
      // Complete one req0 transaction so the pointer moves to requester 0.
      bus.i_req_rs1_data = {32'hAAAA0000, 32'h00000011};
      bus.i_req_rs2_data = {32'h0000BBBB, 32'h00000011};
      bus.i_req_funct3   = {3'b101, 3'b000};
      bus.i_rsp_ready    = 2'b11;
      bus.i_req_valid    = 2'b01;
      #1;
      waited = 0;
      while (bus.o_req_ready == 2'b00 && waited < 10) begin @(negedge clk); #1; waited++; end
      n_checks++; if (bus.o_req_ready !== 2'b01) begin n_errors++; $display("FAIL rc_grant0: got %b expected 01", bus.o_req_ready); end
      @(posedge clk); #1;
      bus.i_req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      bus.i_req_valid = 2'b10;
      #1;
      n_checks++; if (bus.o_req_ready !== 2'b10) begin n_errors++; $display("FAIL rc_grant1: got %b expected 10", bus.o_req_ready); end
      @(posedge clk); #1;
      bus.i_req_valid = 2'b00;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.i_req_valid = 2'b11;
      @(negedge clk);
      n_checks++; if (bus.o_rsp_valid !== 2'b00) begin n_errors++; $display("FAIL rc_no_rsp_after_reset: got %b expected 00", bus.o_rsp_valid); end
      n_checks++; if (bus.o_req_ready !== 2'b01) begin n_errors++; $display("FAIL rc_req0_wins: got %b expected 01", bus.o_req_ready); end
      n_checks++; if (bus.o_rsp_taken !== 1'b0 || bus.o_cmp_rs1_data !== 32'd0) begin
         n_errors++; $display("FAIL rc_outputs_cleared: got taken=%b rs1=%h expected 0/0", bus.o_rsp_taken, bus.o_cmp_rs1_data); end
      @(posedge clk); #1;
      bus.i_req_valid = 2'b00;
      seen0 = 1'b0;
      seen1 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.o_rsp_valid[0]) seen0 = 1'b1;
         if (bus.o_rsp_valid[1]) seen1 = 1'b1;
      end
      n_checks++; if (seen1 !== 1'b0) begin n_errors++; $display("FAIL rc_dropped_rsp1: got %b expected 0", seen1); end
      n_checks++; if (seen0 !== 1'b1) begin n_errors++; $display("FAIL rc_rsp0_served: got %b expected 1", seen0); end
   endtask

   initial begin
      rst                = 1'b1;
      bus.i_req_valid    = '0;
      bus.i_req_rs1_data = '0;
      bus.i_req_rs2_data = '0;
      bus.i_req_funct3   = '0;
      bus.i_rsp_ready    = '0;
      test_reset();
      test_decode();
      test_round_robin();
      test_backpressure();
      test_reset_in_cmp();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
